// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the 3-to-8 pulse decoder and its code buffer:
//   CODE_W  width of an encoded command (3 bits, codes 0..7)
//   OUT_W   width of the one-hot output (8 bits)
//   state_e pulse sequencer states (idle, holding a one-hot value, gap)
//   onehot  maps a code to its one-hot select pattern
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // One-hot pattern with bit 'code' set.
    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] base;
        base = {{(OUT_W-1){1'b0}}, 1'b1};
        return base << code;
    endfunction

endpackage

// File: rtl/decoder_3_to_8_pulse_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo_2
// Two-entry FIFO holding pending codes, oldest first.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   flush_i      synchronous clear (wins over push/pop)
//   push_i       write data_i (ignored when full)
//   pop_i        drop the head entry (ignored when empty)
//   data_i       code to store
//   data_o       head entry (valid when !empty_o)
//   full_o       two entries stored
//   empty_o      no entries stored
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module code_fifo_2 import decoder_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [CODE_W-1:0] data_i,
    output logic [CODE_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [CODE_W-1:0] mem_q [2];
    logic [CODE_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= {CODE_W{1'b0}};
            mem_q[1] <= {CODE_W{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/decoder_3_to_8_pulse.sv
// -----------------------------------------------------------------------------
// decoder_3_to_8_pulse
// Accepts 3-bit codes over valid/ready, buffers up to two, and plays each one
// out as a registered one-hot pulse held HOLD cycles followed by GAP zero
// cycles. With GAP==0, queued codes produce back-to-back pulses.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   flush_i      synchronous clear of buffer and sequencer
//   en_i         allows a new pulse to start (a running pulse always finishes)
//   in_valid_i   in_code_i is valid
//   in_ready_o   a code can be accepted (low when full or flushing)
//   in_code_i    code 0..7
//   y_o          registered one-hot output or all zero
//   done_o       high in the last hold cycle of each pulse
//   busy_o       sequencer active or codes pending
// -----------------------------------------------------------------------------
module decoder_3_to_8_pulse import decoder_pkg::*; #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              en_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CODE_W-1:0] in_code_i,
    output logic [OUT_W-1:0]  y_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Loads are HOLD-1 / GAP-1 so the down-counter never wraps.
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [OUT_W-1:0] Y_ZERO    = {OUT_W{1'b0}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic               can_start_s;
    logic [CODE_W-1:0]  head_s;

    // Ready is suppressed while flushing so nothing slips in during the clear.
    assign in_ready_o  = !full_s && !flush_i;
    assign push_s      = in_valid_i && in_ready_o;
    assign can_start_s = en_i && !empty_s;

    code_fifo_2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (in_code_i),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Sequencer next state, counter and output value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        pop_s   = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            y_d     = Y_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (can_start_s) begin
                        pop_s   = 1'b1;
                        y_d     = onehot(head_s);
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        y_d = Y_ZERO;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (GAP > 0) begin
                        y_d     = Y_ZERO;
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else if (can_start_s) begin
                        // No gap configured: chain the next code seamlessly.
                        pop_s   = 1'b1;
                        y_d     = onehot(head_s);
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        y_d     = Y_ZERO;
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (can_start_s) begin
                        pop_s   = 1'b1;
                        y_d     = onehot(head_s);
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    y_d     = Y_ZERO;
                end
            endcase
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            y_q     <= Y_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign y_o    = y_q;
    assign done_o = (state_q == ST_HOLD) && (cnt_q == CNT_ZERO);
    assign busy_o = (state_q != ST_IDLE) || !empty_s;

endmodule
